// File: rtl/bram_sdp_fifo_ctrl.sv
// FIFO controller for one 18K half of a simple-dual-port BRAM: drives both BRAM
// ports and turns the 1-cycle read latency into a first-word-fall-through stream.
module bram_sdp_fifo_ctrl #(
    parameter int DATA_WIDTH  = 18,
    parameter int ADDR_WIDTH  = 10,
    parameter int AFULL_LEVEL = (1 << ADDR_WIDTH) - 4
) (
    input  logic                    CLK_i,
    input  logic                    RST_i,
    input  logic                    FLUSH_i,
    input  logic [DATA_WIDTH-1:0]   WR_DATA_i,
    input  logic                    WR_EN_i,
    output logic                    FULL_o,
    output logic                    ALMOST_FULL_o,
    output logic                    OVERFLOW_o,
    output logic [DATA_WIDTH-1:0]   RD_DATA_o,
    output logic                    RD_VALID_o,
    input  logic                    RD_READY_i,
    output logic [ADDR_WIDTH:0]     COUNT_o,
    output logic [ADDR_WIDTH-1:0]   BRAM_WADDR_o,
    output logic [DATA_WIDTH-1:0]   BRAM_WDATA_o,
    output logic                    BRAM_WEN_o,
    output logic [1:0]              BRAM_BE_o,
    output logic [ADDR_WIDTH-1:0]   BRAM_RADDR_o,
    output logic                    BRAM_REN_o,
    input  logic [DATA_WIDTH-1:0]   BRAM_RDATA_i
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [31:0]           AFULL_W = AFULL_LEVEL;
    localparam logic [ADDR_WIDTH:0]   AFULL_C = AFULL_W[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   r_mem_cnt;
    logic                  r_full;
    logic                  r_ovf;
    logic                  r_inflight;
    logic [1:0]            r_occ;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;

    logic                  w_clr;
    logic                  w_wr_acc;
    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_pend;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic [ADDR_WIDTH:0]   w_mem_nxt;

    // Clear has priority: nothing is written or issued in a reset/flush cycle.
    assign w_clr    = RST_i | FLUSH_i;
    assign w_wr_acc = WR_EN_i & ~r_full & ~w_clr;
    assign w_pop    = (r_occ != 2'd0) & RD_READY_i & ~w_clr;

    // Words that will sit in the skid buffer after this edge without a new issue.
    assign w_pend  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_mem_cnt != '0) & (w_pend < 3'd2) & ~w_clr;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc & ~w_pop)
            w_count_nxt = r_count + CNT_ONE;
        else if (~w_wr_acc & w_pop)
            w_count_nxt = r_count - CNT_ONE;
    end

    always_comb begin
        w_mem_nxt = r_mem_cnt;
        if (w_wr_acc & ~w_issue)
            w_mem_nxt = r_mem_cnt + CNT_ONE;
        else if (~w_wr_acc & w_issue)
            w_mem_nxt = r_mem_cnt - CNT_ONE;
    end

    always_ff @(posedge CLK_i) begin
        if (w_clr) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_mem_cnt <= '0;
            r_full    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_issue)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count   <= w_count_nxt;
            r_mem_cnt <= w_mem_nxt;
            r_full    <= (w_count_nxt == DEPTH_C);
            r_ovf     <= WR_EN_i & r_full;
        end
    end

    // Skid buffer: r_buf0 is always the head; returning BRAM data lands behind it.
    always_ff @(posedge CLK_i) begin
        if (w_clr) begin
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_inflight <= w_issue;
            case ({w_pop, r_inflight})
                2'b10: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b01: begin
                    if (r_occ == 2'd0)
                        r_buf0 <= BRAM_RDATA_i;
                    else
                        r_buf1 <= BRAM_RDATA_i;
                    r_occ <= r_occ + 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf0 <= BRAM_RDATA_i;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= BRAM_RDATA_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign FULL_o        = r_full;
    assign ALMOST_FULL_o = (r_count >= AFULL_C);
    assign OVERFLOW_o    = r_ovf;
    assign COUNT_o       = r_count;
    assign RD_DATA_o     = r_buf0;
    assign RD_VALID_o    = (r_occ != 2'd0);

    assign BRAM_WEN_o    = w_wr_acc;
    assign BRAM_BE_o     = {2{w_wr_acc}};
    assign BRAM_WADDR_o  = r_wr_ptr;
    assign BRAM_WDATA_o  = WR_DATA_i;
    assign BRAM_REN_o    = w_issue;
    assign BRAM_RADDR_o  = r_rd_ptr;

endmodule

// File: tb/tb_bram_sdp_fifo_ctrl.sv
// Self-checking bench for bram_sdp_fifo_ctrl with a BRAM model and a queue-based reference.
module tb_bram_sdp_fifo_ctrl;
    localparam int DW    = 18;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int AFL   = DEPTH - 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, wr_en, rdy;
    logic [DW-1:0] wr_data;
    logic          full, afull, ovf, rd_valid, bram_wen, bram_ren;
    logic [DW-1:0] rd_data, bram_wdata, bram_rdata;
    logic [AW:0]   count;
    logic [AW-1:0] bram_waddr, bram_raddr;
    logic [1:0]    bram_be;

    bram_sdp_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LEVEL(AFL)) dut (
        .CLK_i(clk), .RST_i(rst), .FLUSH_i(flush),
        .WR_DATA_i(wr_data), .WR_EN_i(wr_en),
        .FULL_o(full), .ALMOST_FULL_o(afull), .OVERFLOW_o(ovf),
        .RD_DATA_o(rd_data), .RD_VALID_o(rd_valid), .RD_READY_i(rdy),
        .COUNT_o(count),
        .BRAM_WADDR_o(bram_waddr), .BRAM_WDATA_o(bram_wdata), .BRAM_WEN_o(bram_wen),
        .BRAM_BE_o(bram_be), .BRAM_RADDR_o(bram_raddr), .BRAM_REN_o(bram_ren),
        .BRAM_RDATA_i(bram_rdata)
    );

    // Simple-dual-port BRAM with registered read data
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bram_wen) mem[bram_waddr] <= bram_wdata;
        if (bram_ren) bram_rdata <= mem[bram_raddr];
    end

    // Reference: ordered queue of words stamped with the edge that accepted them.
    // A head word is visible two edges after its acceptance.
    typedef struct { logic [DW-1:0] d; int t; } ent_t;
    ent_t q[$];
    int   cyc = 0;
    bit   exp_ovf = 1'b0;
    bit   m_v, m_f;

    function automatic bit m_valid();
        return (q.size() > 0) && (cyc - q[0].t >= 2);
    endfunction

    always @(posedge clk) begin
        m_v = m_valid();
        m_f = (q.size() == DEPTH);
        cyc++;
        if (rst || flush) begin
            q.delete();
            exp_ovf = 1'b0;
        end else begin
            exp_ovf = wr_en && m_f;
            if (m_v && rdy) void'(q.pop_front());
            if (wr_en && !m_f) q.push_back('{d: wr_data, t: cyc});
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit ev;
        ev = m_valid();
        chk("count", 32'(count), 32'(q.size()));
        chk("rd_valid", 32'(rd_valid), 32'(ev));
        if (ev) chk("rd_data", 32'(rd_data), 32'(q[0].d));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("almost_full", 32'(afull), 32'(q.size() >= AFL));
        chk("overflow", 32'(ovf), 32'(exp_ovf));
        chk("bram_be", 32'(bram_be), 32'({2{bram_wen}}));
        chk("bram_wen", 32'(bram_wen), 32'(wr_en && (q.size() != DEPTH) && !rst && !flush));
        if (bram_wen) chk("bram_wdata", 32'(bram_wdata), 32'(wr_data));
    endtask

    task automatic drive(input bit r, input bit f, input bit w, input logic [DW-1:0] d, input bit rd);
        rst = r; flush = f; wr_en = w; wr_data = d; rdy = rd;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        bit rst; bit wr; logic [DW-1:0] d; bit rdy;
        bit ev; logic [DW-1:0] ed; int ec; bit ef;
    } vec_t;
    vec_t vt [11];

    logic [DW-1:0] held;
    bit            stalled;

    initial begin
        vt[0]  = '{1, 0, 18'h0,  0, 0, 18'h0,  0, 0};
        vt[1]  = '{0, 1, 18'h2A, 0, 0, 18'h0,  1, 0};
        vt[2]  = '{0, 0, 18'h0,  0, 0, 18'h0,  1, 0};
        vt[3]  = '{0, 0, 18'h0,  0, 1, 18'h2A, 1, 0};
        vt[4]  = '{0, 0, 18'h0,  1, 0, 18'h0,  0, 0};
        vt[5]  = '{0, 1, 18'h3,  1, 0, 18'h0,  1, 0};
        vt[6]  = '{0, 1, 18'h4,  1, 0, 18'h0,  2, 0};
        vt[7]  = '{0, 0, 18'h0,  1, 1, 18'h3,  2, 0};
        vt[8]  = '{0, 0, 18'h0,  1, 1, 18'h4,  1, 0};
        vt[9]  = '{0, 0, 18'h0,  0, 1, 18'h4,  1, 0};
        vt[10] = '{0, 0, 18'h0,  1, 0, 18'h0,  0, 0};

        drive(1, 0, 0, '0, 0);
        step(); step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_ren", 32'(bram_ren), 32'd0);

        // Latency and basic flow vectors
        for (int i = 0; i < 11; i++) begin
            drive(vt[i].rst, 0, vt[i].wr, vt[i].d, vt[i].rdy);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vt[i].ev));
            if (vt[i].ev) chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vt[i].ed));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].ec));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vt[i].ef));
        end

        // Reset mid-stream with 5 words held, then no stale data
        for (int i = 0; i < 5; i++) begin drive(0, 0, 1, DW'(32'h100 + i), 0); step(); end
        drive(0, 0, 0, '0, 0); step(); step();
        chk("mid_count5", 32'(count), 32'd5);
        drive(1, 0, 0, '0, 0); step();
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_data", 32'(rd_data), 32'd0);
        drive(0, 0, 1, 18'h155, 0); step();
        drive(0, 0, 0, '0, 0); step(); step(); step();
        chk("after_rst_valid", 32'(rd_valid), 32'd1);
        chk("after_rst_data", 32'(rd_data), 32'h155);
        drive(0, 0, 0, '0, 1);
        for (int i = 0; i < 5; i++) step();
        chk("after_rst_empty", 32'(rd_valid), 32'd0);

        // Flush behaves like reset
        for (int i = 0; i < 3; i++) begin drive(0, 0, 1, DW'(32'h200 + i), 0); step(); end
        drive(0, 1, 0, '0, 0); step();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(rd_valid), 32'd0);
        drive(0, 0, 0, '0, 0); step(); step(); step();
        chk("flush_stays_empty", 32'(rd_valid), 32'd0);

        // Fill to full, then one overflowing write
        for (int i = 0; i < DEPTH; i++) begin drive(0, 0, 1, DW'(i), 0); step(); end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'(DEPTH));
        chk("fill_afull", 32'(afull), 32'd1);
        drive(0, 0, 1, 18'h3FFFF, 0); step();
        chk("ovf_pulse", 32'(ovf), 32'd1);
        chk("ovf_count", 32'(count), 32'(DEPTH));
        drive(0, 0, 0, '0, 0); step();
        chk("ovf_clear", 32'(ovf), 32'd0);

        // Drain: every cycle must pop the next value with no bubble
        drive(0, 0, 0, '0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_valid", 32'(rd_valid), 32'd1);
            chk("drain_data", 32'(rd_data), 32'(i));
            step();
        end
        chk("drain_empty", 32'(count), 32'd0);
        for (int i = 0; i < 300; i++) begin drive(0, 0, 1, DW'(32'h1000 + i), 1); step(); end
        drive(0, 0, 0, '0, 1);
        for (int i = 0; i < 6; i++) step();

        // Simultaneous write and pop at 1023 words
        drive(1, 0, 0, '0, 0); step();
        for (int i = 0; i < DEPTH - 1; i++) begin drive(0, 0, 1, DW'(32'h2000 + i), 0); step(); end
        drive(0, 0, 0, '0, 0); step(); step();
        chk("n1023_count", 32'(count), 32'(DEPTH - 1));
        drive(0, 0, 1, 18'h3ABC, 1); step();
        chk("n1023_count_kept", 32'(count), 32'(DEPTH - 1));
        chk("n1023_full", 32'(full), 32'd0);
        chk("n1023_afull", 32'(afull), 32'd1);

        // Backpressure with ready pattern 1,0,0,1 across pointer wrap
        stalled = 1'b0;
        held = '0;
        for (int i = 0; i < 400; i++) begin
            drive(0, 0, 1, DW'($urandom), (i % 4 == 0) || (i % 4 == 3));
            if (stalled && rd_valid) chk("stall_hold", 32'(rd_data), 32'(held));
            stalled = rd_valid && !rdy;
            held = rd_data;
            step();
        end

        // Randomized traffic against the reference
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 2500; i++) begin
                int wp, rp;
                wp = (ph == 0) ? 90 : (ph == 1) ? 30 : 60;
                rp = (ph == 0) ? 30 : (ph == 1) ? 90 : 60;
                drive(0, ($urandom_range(499) == 0), ($urandom_range(99) < wp),
                      DW'($urandom), ($urandom_range(99) < rp));
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_sdp_fifo_ctrl.md
Name: bram_sdp_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly in front of one 18K half of the 2x18 simple-dual-port BRAM macro.
- Drives the BRAM write port (address, enable, byte enables, data) and the read port (address, enable).
- Consumes the 1-cycle-latency read data and presents it first-word-fall-through on a valid/ready interface.
- Sustains one write and one read per clock.

Parameters:
- DATA_WIDTH, 18, FIFO word width; legal values 1, 2, 4, 8, 9, 16, 18 (matches BRAM CFG_DBITS).
- ADDR_WIDTH, 10, BRAM address bits used; DEPTH = 2**ADDR_WIDTH words.
- AFULL_LEVEL, DEPTH-4, COUNT_o threshold for ALMOST_FULL_o.

Ports:
- CLK_i  in  1  single clock; all logic on rising edge.
- RST_i  in  1  synchronous active-high reset.
- FLUSH_i  in  1  synchronous clear of FIFO contents; same effect as reset.
- WR_DATA_i  in  DATA_WIDTH  write word.
- WR_EN_i  in  1  write request.
- FULL_o  out  1  FIFO full; a write is accepted only when low.
- ALMOST_FULL_o  out  1  COUNT_o >= AFULL_LEVEL.
- OVERFLOW_o  out  1  one-cycle pulse on a write attempted while full.
- RD_DATA_o  out  DATA_WIDTH  head word.
- RD_VALID_o  out  1  RD_DATA_o holds a valid head word.
- RD_READY_i  in  1  consumer accepts; pop = RD_VALID_o & RD_READY_i.
- COUNT_o  out  ADDR_WIDTH+1  total words held.
- BRAM_WADDR_o  out  ADDR_WIDTH  write address.
- BRAM_WDATA_o  out  DATA_WIDTH  write data.
- BRAM_WEN_o  out  1  write enable.
- BRAM_BE_o  out  2  byte enables, both = BRAM_WEN_o.
- BRAM_RADDR_o  out  ADDR_WIDTH  read address.
- BRAM_REN_o  out  1  read enable.
- BRAM_RDATA_i  in  DATA_WIDTH  BRAM read data, valid the cycle after BRAM_REN_o.

Behaviour:
- Reset:
  - On RST_i or FLUSH_i: wr_ptr, rd_ptr, COUNT_o, in-flight flag and both output-buffer entries clear.
  - FULL_o=0, ALMOST_FULL_o=0, OVERFLOW_o=0, RD_VALID_o=0, RD_DATA_o=0, BRAM_WEN_o=0, BRAM_REN_o=0.
  - An in-flight BRAM read is discarded. RST_i has priority over all other inputs.
- Write path (combinational to the BRAM):
  - wr_acc = WR_EN_i & ~FULL_o.
  - BRAM_WEN_o = wr_acc; BRAM_WADDR_o = wr_ptr; BRAM_WDATA_o = WR_DATA_i.
  - wr_ptr increments on wr_acc and wraps at DEPTH.
- OVERFLOW_o: registered, = WR_EN_i & FULL_o. Data is dropped; state is unchanged.
- Read prefetch:
  - mem_cnt = words written but not yet read-issued.
  - Issue when mem_cnt>0 and (out_occ + inflight - pop) < 2, where out_occ is 0..2 and inflight is 0..1.
  - On issue: BRAM_REN_o=1, BRAM_RADDR_o=rd_ptr, rd_ptr increments and wraps.
  - The next cycle, BRAM_RDATA_i is captured into the 2-entry output buffer (skid).
- Output:
  - RD_DATA_o/RD_VALID_o always show the buffer head in FIFO order.
  - The head changes only on pop or when the buffer is empty.
  - RD_DATA_o is held while RD_VALID_o=1 and RD_READY_i=0.
- Latency: a word written into an empty FIFO at edge E0 appears on RD_VALID_o after edge E2 (read issued in cycle E0→E1, captured at E2).
- Throughput: with continuous writes and RD_READY_i=1, one pop per cycle after the initial latency; no bubbles.
- COUNT_o: +1 on wr_acc, -1 on pop, unchanged when both occur in the same cycle. It includes words in the BRAM, in flight and in the output buffer.
- FULL_o: registered, = (next COUNT_o == DEPTH). A pop at full clears FULL_o at the next edge; a write in that same cycle is rejected.
- Empty read: RD_READY_i with RD_VALID_o=0 has no effect.
- Address collision: a write and a read issue never target the same address in the same cycle, because read issue needs mem_cnt>0.
- Wrap: pointers wrap DEPTH-1→0 seamlessly; ordering is preserved across the wrap.
- DATA_WIDTH=9: passed through unchanged; bit placement is handled by the BRAM map.

Test Plan:
- Reset/flush: assert RST_i mid-stream with 5 words held → next cycle COUNT_o=0, RD_VALID_o=0, FULL_o=0; a later single write of 0x155 reads back 0x155 only, with no stale data.
- Latency: empty FIFO, write 0x2A at E0 with RD_READY_i=0 → RD_VALID_o=0 after E1, 1 after E2, RD_DATA_o=0x2A, COUNT_o=1.
- Fill to full (DEPTH=1024): write 0..1023 with no reads → FULL_o=1 after the 1024th accepted write, COUNT_o=1024; the 1025th write pulses OVERFLOW_o for one cycle and COUNT_o stays 1024.
- Drain and wrap: after full, pop all with RD_READY_i=1 → 1024 consecutive pops of values 0..1023, no bubbles after the first valid; continue 300 more writes/reads across the wrap, all in order.
- Backpressure: stream with RD_READY_i toggling 1,0,0,1 → no lost or duplicated words; RD_DATA_o is stable while stalled; out_occ never exceeds 2.
- Simultaneous write and pop at COUNT_o=1023 → COUNT_o stays 1023 and FULL_o stays 0; ALMOST_FULL_o=1 with AFULL_LEVEL=1020.
